// File: rtl/xcvr_fanout_pkg.sv
// rtl/xcvr_fanout_pkg.sv - shared types and constants for the transceiver reconfiguration fanout
package xcvr_fanout_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int          ERR_CNT_W        = 8;

endpackage

// File: rtl/xcvr_fanout_watchdog.sv
// rtl/xcvr_fanout_watchdog.sv - ISSUE-cycle counter raising expire on the last allowed cycle
module xcvr_fanout_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // start is the accept cycle, so the first ISSUE cycle sees a count of zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (active) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = active && (cnt_q == LIMIT);

endmodule

// File: rtl/xcvr_reconfig_mm_fanout.sv
// rtl/xcvr_reconfig_mm_fanout.sv - single-outstanding MM fanout to NUM_CH reconfig channels
// Optional watchdog abort enabled by defining XCVR_FANOUT_TIMEOUT_EN.
module xcvr_reconfig_mm_fanout
  import xcvr_fanout_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int HDL_ADDR_WIDTH = 13,
  parameter int NUM_CH         = 4,
  parameter int CH_SEL_WIDTH   = 2,
  parameter int CH_ADDR_WIDTH  = HDL_ADDR_WIDTH - CH_SEL_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              s0_waitrequest,
  output logic [DATA_WIDTH-1:0]             s0_readdata,
  output logic                              s0_readdatavalid,
  input  logic [HDL_ADDR_WIDTH-1:0]         s0_address,
  input  logic                              s0_read,
  input  logic                              s0_write,
  input  logic [DATA_WIDTH-1:0]             s0_writedata,
  input  logic [3:0]                        s0_byteenable,
  output logic [NUM_CH*CH_ADDR_WIDTH-1:0]   ch_address,
  output logic [NUM_CH-1:0]                 ch_read,
  output logic [NUM_CH-1:0]                 ch_write,
  output logic [NUM_CH*DATA_WIDTH-1:0]      ch_writedata,
  output logic [NUM_CH*4-1:0]               ch_byteenable,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      ch_readdata,
  input  logic [NUM_CH-1:0]                 ch_waitrequest,
  input  logic                              err_clear,
  output logic                              err_flag,
  output logic [ERR_CNT_W-1:0]              err_count
);

  localparam logic [CH_SEL_WIDTH:0]   NUM_CH_L = (CH_SEL_WIDTH + 1)'(NUM_CH);
  localparam logic [ERR_CNT_W-1:0]    CNT_MAX  = '1;

  state_t state_q, state_d;

  logic [CH_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [3:0]               be_q;
  logic                     rd_q;
  logic [CH_SEL_WIDTH-1:0]  sel_q;
  logic [NUM_CH-1:0]        ch_read_q, ch_write_q;
  logic                     rdv_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     err_flag_q;
  logic [ERR_CNT_W-1:0]     err_cnt_q;

  logic [CH_SEL_WIDTH-1:0]  sel;
  logic                     take, accept, complete, abort, oor, dual, err_event;
  logic                     sel_wait;
  logic [DATA_WIDTH-1:0]    sel_rdata;
  logic [NUM_CH-1:0]        sel_onehot;

  assign sel  = s0_address[HDL_ADDR_WIDTH-1 -: CH_SEL_WIDTH];
  assign oor  = ({1'b0, sel} >= NUM_CH_L);
  assign dual = s0_read & s0_write;
  assign take = (state_q == IDLE) && (s0_read || s0_write);

  // Incoming decode uses the live address; the completion mux uses the latched select
  always_comb begin
    sel_wait   = 1'b0;
    sel_rdata  = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == CH_SEL_WIDTH'(i)) begin
        sel_wait  = ch_waitrequest[i];
        sel_rdata = ch_readdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      sel_onehot[i] = (sel == CH_SEL_WIDTH'(i));
    end
  end

`ifdef XCVR_FANOUT_TIMEOUT_EN
  logic expire;

  xcvr_fanout_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .active (state_q == ISSUE),
    .expire (expire)
  );

  // A completion in the expiry cycle wins over the abort
  assign abort = (state_q == ISSUE) && sel_wait && expire;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (take && !oor) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!sel_wait) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_event = (take && (dual || oor)) || abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= 1'b0;
      sel_q      <= '0;
      ch_read_q  <= '0;
      ch_write_q <= '0;
      rdv_q      <= 1'b0;
      rdata_q    <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rdv_q <= 1'b0;
      if (take) begin
        addr_q  <= s0_address[CH_ADDR_WIDTH-1:0];
        wdata_q <= s0_writedata;
        be_q    <= s0_byteenable;
        rd_q    <= s0_read;
        sel_q   <= sel;
      end
      if (accept) begin
        ch_read_q  <= s0_read ? sel_onehot : '0;
        ch_write_q <= s0_read ? '0 : sel_onehot;
      end
      if (take && oor && s0_read) begin
        rdv_q   <= 1'b1;
        rdata_q <= ERR_DATA;
      end
      if (complete || abort) begin
        ch_read_q  <= '0;
        ch_write_q <= '0;
        if (rd_q) begin
          rdv_q   <= 1'b1;
          rdata_q <= complete ? sel_rdata : ERR_DATA;
        end
      end
      // A new error outranks a simultaneous clear
      if (err_event) begin
        err_flag_q <= 1'b1;
        if (err_clear) begin
          err_cnt_q <= ERR_CNT_W'(1);
        end else if (err_cnt_q != CNT_MAX) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end else if (err_clear) begin
        err_flag_q <= 1'b0;
        err_cnt_q  <= '0;
      end
    end
  end

  assign s0_waitrequest   = (state_q != IDLE);
  assign s0_readdata      = rdata_q;
  assign s0_readdatavalid = rdv_q;
  assign ch_read          = ch_read_q;
  assign ch_write         = ch_write_q;
  assign ch_address       = {NUM_CH{addr_q}};
  assign ch_writedata     = {NUM_CH{wdata_q}};
  assign ch_byteenable    = {NUM_CH{be_q}};
  assign err_flag         = err_flag_q;
  assign err_count        = err_cnt_q;

endmodule
